tlk2711_rx_deframer: RTL and testbench
======================================

// Module: tlk2711_rx_deframer
// PURPOSE
//  Receive-side deframer for the TLK2711 link, upstream of the RX DMA write path in tlk2711_top.
//  Acquires word sync on idles and parses SOF/LEN/payload/CKSUM/EOF frames from the transceiver's rxd/rk bits.
//  Buffers payload in a FWFT FIFO as a valid/ready stream, and reports per-frame status plus loss-of-sync.
// PARAMETERS
//  DLEN_WIDTH  16  width of the LEN field and of o_frame_len
//  MAX_LEN     4096  largest legal payload length, in 16-bit words
//  FIFO_DEPTH  64  payload FIFO entries; power of 2, >=4
//  SYNC_CNT    4  consecutive idle words needed to declare sync
//  LOSS_CNT    4  consecutive code violations needed to declare loss
// PORTS
//  clk           in   1   single clock; transceiver rx pins and all logic run on it
//  rst           in   1   synchronous, active-high reset
//  i_enable      in   1   register-bus enable; 0 forces UNSYNC
//  i_2711_rkmsb  in   1   K flag, rxd[15:8]
//  i_2711_rklsb  in   1   K flag, rxd[7:0]
//  i_2711_rxd    in   16  received word
//  o_m_data      out  16  payload word (FIFO head)
//  o_m_valid     out  1   FIFO non-empty
//  o_m_last      out  1   final word of a frame, or a terminator
//  o_m_err       out  1   entry is an error terminator (o_m_data=0)
//  i_m_ready     in   1   pop when o_m_valid&i_m_ready
//  o_frame_done  out  1   1-cycle pulse: frame received without error
//  o_frame_err   out  1   1-cycle pulse: frame error; o_err_code is valid this cycle
//  o_err_code    out  3   1 LEN, 2 BADK, 3 NO_EOF, 4 CKSUM, 5 OVF, 6 LOSS, 7 ABORT
//  o_frame_len   out  DLEN_WIDTH  LEN of the last completed or errored frame
//  o_sync        out  1   level: link synced
//  o_loss_irq    out  1   1-cycle pulse on a sync -> loss transition
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state UNSYNC; counters and checksum 0.
//  Input word classes, decoded after one input register stage:
//   IDLE = rk 01, rxd C5BC; SOF = rk 11, FBFB; EOF = rk 11, FDFD; DATA = rk 00.
//   Any other combination is a code violation (CV).
//  Loss of sync: a CV counter resets on any non-CV word. Reaching LOSS_CNT while o_sync=1 does all of:
//   o_sync<=0, 1 o_loss_irq pulse, state UNSYNC, and err 6 if a frame is open.
//  Idle handling: IDLE inside a frame is skipped (clock compensation) and changes no state.
//  States:
//   UNSYNC : count consecutive IDLE; at SYNC_CNT -> IDLE state, o_sync<=1.
//   IDLE   : SOF -> HDR. Stray DATA is discarded with no error.
//   HDR    : DATA = LEN. LEN==0 or LEN>MAX_LEN -> err 1, DROP. Otherwise rem<=LEN, sum<=0, -> PAYLOAD.
//   PAYLOAD: each DATA is pushed with last=(rem==1); sum<=sum+word mod 2^16; at rem==1 -> CKSUM.
//            SOF/EOF here -> err 2, DROP.
//   CKSUM  : DATA compared with sum; a mismatch is latched; -> EOFW. SOF/EOF here -> err 2, DROP.
//   EOFW   : EOF -> o_frame_done, or err 4 if a mismatch was latched; -> IDLE.
//            DATA -> err 3, DROP. SOF -> err 3, then HDR.
//   DROP   : discard words until EOF (-> IDLE) or SOF (-> HDR).
//  Error reporting: an error raised while a frame has pushed words but not its last word also queues a
//   terminator entry {last=1, err=1, data=0}. Errors 1 and 4 never push a terminator.
//  FIFO: push only when count<FIFO_DEPTH, regardless of a same-cycle pop.
//   A DATA word arriving in PAYLOAD while full is dropped -> err 5, DROP, terminator queued.
//  Pending terminator: pushed at the first non-full cycle, ahead of any later payload.
//   New-frame words that find the terminator still pending -> that frame also takes err 5.
//  o_frame_len updates on the same cycle as o_frame_done or o_frame_err. o_frame_done and o_frame_err
//   are mutually exclusive. Exactly one status pulse per SOF that reached HDR.
//  Latency: a pin word sampled at edge N reaches the FIFO at N+1 and o_m_data at N+2 (FWFT).
//   EOF at edge N -> status pulse at N+2.
//  i_enable=0: state UNSYNC and o_sync=0 on the next cycle. An open frame gets err 7 plus a terminator.
//   No o_loss_irq is raised. The FIFO is kept and keeps draining.
//  rst mid-frame: everything clears, including FIFO contents; no pulses or terminators are emitted.
// TESTING
//  T1: 4 IDLE -> o_sync=1. SOF, LEN=3, 1111/2222/3333, CKSUM=6666, EOF, ready=1 -> 3 beats, last on 3333,
//      o_frame_done=1, o_frame_len=3.
//  T2: as T1 but CKSUM=6667 -> all 3 beats, o_frame_err=1, code 4, no terminator.
//  T3: ready=0, FIFO_DEPTH=64, LEN=100 -> 64 words buffered, err 5, terminator pushed after first pop,
//      next good frame is delivered intact.
//  T4: 4 CV words mid-payload (rk=10) -> o_loss_irq once, o_sync=0, err 6, terminator;
//      4 IDLE later -> o_sync=1.
//  T5: LEN=0, then LEN=MAX_LEN+1 -> err 1 each, no FIFO push. IDLE inserted between payload words
//      -> frame done, sum excludes idles.
//  T6: i_enable=0 mid-frame -> err 7 plus terminator, no loss irq. rst mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tlk2711_rx_deframer.sv
// TLK2711 receive deframer: word sync on idles, SOF/LEN/payload/CKSUM/EOF parsing,
// payload buffered in a first-word-fall-through FIFO with per-frame status and loss-of-sync.
module tlk2711_rx_deframer #(
  parameter int DLEN_WIDTH = 16,
  parameter int MAX_LEN    = 4096,
  parameter int FIFO_DEPTH = 64,
  parameter int SYNC_CNT   = 4,
  parameter int LOSS_CNT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_2711_rkmsb,
  input  logic                  i_2711_rklsb,
  input  logic [15:0]           i_2711_rxd,
  output logic [15:0]           o_m_data,
  output logic                  o_m_valid,
  output logic                  o_m_last,
  output logic                  o_m_err,
  input  logic                  i_m_ready,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic [2:0]            o_err_code,
  output logic [DLEN_WIDTH-1:0] o_frame_len,
  output logic                  o_sync,
  output logic                  o_loss_irq
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SCW = $clog2(SYNC_CNT + 1);
  localparam int LCW = $clog2(LOSS_CNT + 1);
  localparam logic [SCW-1:0]        SYNC_LAST = SCW'(SYNC_CNT - 1);
  localparam logic [LCW-1:0]        LOSS_LAST = LCW'(LOSS_CNT - 1);
  localparam logic [DLEN_WIDTH-1:0] MAX_LEN_W = DLEN_WIDTH'(MAX_LEN);
  localparam logic [DLEN_WIDTH-1:0] ONE_W     = DLEN_WIDTH'(1);
  localparam logic [AW:0]           CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] E_LEN   = 3'd1;
  localparam logic [2:0] E_BADK  = 3'd2;
  localparam logic [2:0] E_NOEOF = 3'd3;
  localparam logic [2:0] E_CKSUM = 3'd4;
  localparam logic [2:0] E_OVF   = 3'd5;
  localparam logic [2:0] E_LOSS  = 3'd6;
  localparam logic [2:0] E_ABORT = 3'd7;

  typedef enum logic [2:0] {W_NONE, W_IDLE, W_SOF, W_EOF, W_DATA, W_CV} wcls_t;
  typedef enum logic [2:0] {S_UNSYNC, S_IDLE, S_HDR, S_PAYLOAD, S_CKSUM, S_EOFW, S_DROP} state_t;

  logic [15:0] rxd_p0, rxd_p1;
  logic [1:0]  rk_p0;
  logic        vld_p0;
  wcls_t       cls_p0, cls_p1;

  state_t                state, state_n;
  logic [SCW-1:0]        idle_cnt, idle_cnt_n;
  logic [LCW-1:0]        cv_cnt, cv_cnt_n;
  logic [DLEN_WIDTH-1:0] rem, rem_n, len, len_n, flen_n, len_word;
  logic [15:0]           sum, sum_n;
  logic                  mism, mism_n, pushed, pushed_n;
  logic                  done_n, err_n, loss_n;
  logic [2:0]            code_n;
  logic                  dpush, need_term, in_frame, mid_frame;

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, term_pend, term_req, term_pend_n;
  logic [17:0]   wr_word;

  // Stage p0: raw pins registered; decoded into word classes on the way to p1
  always_ff @(posedge clk) begin
    rxd_p0 <= i_2711_rxd;
    rk_p0  <= {i_2711_rkmsb, i_2711_rklsb};
    rxd_p1 <= rxd_p0;
    if (rst) begin
      vld_p0 <= 1'b0;
      cls_p1 <= W_NONE;
    end else begin
      vld_p0 <= 1'b1;
      cls_p1 <= cls_p0;
    end
  end

  always_comb begin
    cls_p0 = W_NONE;
    if (vld_p0) begin
      if (rk_p0 == 2'b01 && rxd_p0 == 16'hC5BC)      cls_p0 = W_IDLE;
      else if (rk_p0 == 2'b11 && rxd_p0 == 16'hFBFB) cls_p0 = W_SOF;
      else if (rk_p0 == 2'b11 && rxd_p0 == 16'hFDFD) cls_p0 = W_EOF;
      else if (rk_p0 == 2'b00)                       cls_p0 = W_DATA;
      else                                           cls_p0 = W_CV;
    end
  end

  // Stage p1: frame state machine acts on the decoded word
  assign len_word  = DLEN_WIDTH'(rxd_p1);
  assign in_frame  = (state == S_HDR) || (state == S_PAYLOAD) || (state == S_CKSUM) || (state == S_EOFW);
  assign mid_frame = (state == S_PAYLOAD) && pushed;

  always_comb begin
    state_n    = state;
    idle_cnt_n = idle_cnt;
    cv_cnt_n   = cv_cnt;
    rem_n      = rem;
    len_n      = len;
    sum_n      = sum;
    mism_n     = mism;
    pushed_n   = pushed;
    flen_n     = o_frame_len;
    code_n     = o_err_code;
    done_n     = 1'b0;
    err_n      = 1'b0;
    loss_n     = 1'b0;
    dpush      = 1'b0;
    need_term  = 1'b0;
    if (!i_enable) begin
      state_n    = S_UNSYNC;
      idle_cnt_n = '0;
      cv_cnt_n   = '0;
      if (in_frame) begin
        err_n = 1'b1; code_n = E_ABORT; flen_n = len; need_term = mid_frame;
      end
    end else if (cls_p1 == W_CV) begin
      idle_cnt_n = '0;
      if (cv_cnt != LOSS_LAST) cv_cnt_n = cv_cnt + 1'b1;
      if (cv_cnt == LOSS_LAST && state != S_UNSYNC) begin
        loss_n  = 1'b1;
        state_n = S_UNSYNC;
        if (in_frame) begin
          err_n = 1'b1; code_n = E_LOSS; flen_n = len; need_term = mid_frame;
        end
      end
    end else if (cls_p1 == W_IDLE && state != S_UNSYNC) begin
      cv_cnt_n = '0;
    end else if (cls_p1 != W_NONE) begin
      cv_cnt_n = '0;
      unique case (state)
        S_UNSYNC: begin
          if (cls_p1 == W_IDLE) begin
            if (idle_cnt == SYNC_LAST) begin
              state_n = S_IDLE; idle_cnt_n = '0;
            end else begin
              idle_cnt_n = idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt_n = '0;
          end
        end
        S_IDLE, S_DROP: begin
          if (cls_p1 == W_SOF) begin
            state_n = S_HDR; len_n = '0; pushed_n = 1'b0;
          end else if (cls_p1 == W_EOF && state == S_DROP) begin
            state_n = S_IDLE;
          end
        end
        S_HDR: begin
          if (cls_p1 == W_DATA) begin
            if (len_word == '0 || len_word > MAX_LEN_W) begin
              err_n = 1'b1; code_n = E_LEN; flen_n = len_word; state_n = S_DROP;
            end else begin
              len_n = len_word; rem_n = len_word; sum_n = '0; mism_n = 1'b0;
              pushed_n = 1'b0; state_n = S_PAYLOAD;
            end
          end else begin
            err_n = 1'b1; code_n = E_BADK; flen_n = len; state_n = S_DROP;
          end
        end
        S_PAYLOAD: begin
          if (cls_p1 == W_DATA && !full && !term_pend) begin
            dpush    = 1'b1;
            pushed_n = 1'b1;
            sum_n    = sum + rxd_p1;
            rem_n    = rem - 1'b1;
            if (rem == ONE_W) state_n = S_CKSUM;
          end else begin
            err_n     = 1'b1;
            code_n    = (cls_p1 == W_DATA) ? E_OVF : E_BADK;
            flen_n    = len;
            state_n   = S_DROP;
            need_term = pushed;
          end
        end
        S_CKSUM: begin
          if (cls_p1 == W_DATA) begin
            mism_n = (rxd_p1 != sum); state_n = S_EOFW;
          end else begin
            err_n = 1'b1; code_n = E_BADK; flen_n = len; state_n = S_DROP;
          end
        end
        S_EOFW: begin
          flen_n = len;
          if (cls_p1 == W_EOF) begin
            state_n = S_IDLE;
            if (mism) begin
              err_n = 1'b1; code_n = E_CKSUM;
            end else begin
              done_n = 1'b1;
            end
          end else begin
            err_n  = 1'b1;
            code_n = E_NOEOF;
            if (cls_p1 == W_SOF) begin
              state_n = S_HDR; len_n = '0; pushed_n = 1'b0;
            end else begin
              state_n = S_DROP;
            end
          end
        end
        default: state_n = S_UNSYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_UNSYNC;
      idle_cnt     <= '0;
      cv_cnt       <= '0;
      rem          <= '0;
      len          <= '0;
      sum          <= '0;
      mism         <= 1'b0;
      pushed       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= '0;
      o_frame_len  <= '0;
      o_loss_irq   <= 1'b0;
    end else begin
      state        <= state_n;
      idle_cnt     <= idle_cnt_n;
      cv_cnt       <= cv_cnt_n;
      rem          <= rem_n;
      len          <= len_n;
      sum          <= sum_n;
      mism         <= mism_n;
      pushed       <= pushed_n;
      o_frame_done <= done_n;
      o_frame_err  <= err_n;
      o_err_code   <= code_n;
      o_frame_len  <= flen_n;
      o_loss_irq   <= loss_n;
    end
  end

  assign o_sync = (state != S_UNSYNC);

  // Stage p2: FIFO write; a pending terminator always goes in before later payload
  assign full     = (count == CNT_FULL);
  assign pop      = o_m_valid & i_m_ready;
  assign term_req = term_pend | need_term;

  always_comb begin
    wr_en       = 1'b0;
    wr_word     = {2'b00, rxd_p1};
    term_pend_n = term_req;
    if (dpush) begin
      wr_en   = 1'b1;
      wr_word = {1'b0, (rem == ONE_W), rxd_p1};
    end else if (term_req && !full) begin
      wr_en       = 1'b1;
      wr_word     = {2'b11, 16'h0000};
      term_pend_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      term_pend <= 1'b0;
    end else begin
      term_pend <= term_pend_n;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_m_valid = (count != '0);
  assign o_m_data  = o_m_valid ? mem[rd_ptr][15:0] : 16'h0000;
  assign o_m_last  = o_m_valid & mem[rd_ptr][16];
  assign o_m_err   = o_m_valid & mem[rd_ptr][17];

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// Directed bench for tlk2711_rx_deframer: sync, good/bad frames, overflow, loss, abort and reset.
module tb_tlk2711_rx_deframer;

  logic        clk = 1'b0;
  logic        rst, i_enable, i_2711_rkmsb, i_2711_rklsb, i_m_ready;
  logic [15:0] i_2711_rxd;
  logic [15:0] o_m_data;
  logic        o_m_valid, o_m_last, o_m_err, o_frame_done, o_frame_err, o_sync, o_loss_irq;
  logic [2:0]  o_err_code;
  logic [15:0] o_frame_len;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_done, n_err, n_loss;
  logic [2:0]  last_code;
  logic [15:0] last_len;
  logic [17:0] beats[$];

  tlk2711_rx_deframer #(
    .DLEN_WIDTH(16), .MAX_LEN(4096), .FIFO_DEPTH(64), .SYNC_CNT(4), .LOSS_CNT(4)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_2711_rkmsb(i_2711_rkmsb), .i_2711_rklsb(i_2711_rklsb), .i_2711_rxd(i_2711_rxd),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .o_m_last(o_m_last), .o_m_err(o_m_err),
    .i_m_ready(i_m_ready), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
    .o_err_code(o_err_code), .o_frame_len(o_frame_len), .o_sync(o_sync), .o_loss_irq(o_loss_irq)
  );

  always #5 clk = ~clk;

  // Record status pulses and popped beats {err,last,data} half a cycle after each edge
  always @(negedge clk) begin
    if (rst) begin
      n_done = 0; n_err = 0; n_loss = 0; last_code = 3'd0; last_len = 16'd0;
      beats.delete();
    end else begin
      if (o_frame_done) begin n_done++; last_len = o_frame_len; end
      if (o_frame_err) begin n_err++; last_code = o_err_code; last_len = o_frame_len; end
      if (o_loss_irq) n_loss++;
      if (o_m_valid && i_m_ready) beats.push_back({o_m_err, o_m_last, o_m_data});
    end
  end

  function automatic logic [17:0] beat_at(int i);
    return (i < beats.size()) ? beats[i] : 18'h3FFFF;
  endfunction

  task automatic drive(input logic [1:0] rk, input logic [15:0] d);
    {i_2711_rkmsb, i_2711_rklsb} = rk;
    i_2711_rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();           drive(2'b01, 16'hC5BC); endtask
  task automatic sof();            drive(2'b11, 16'hFBFB); endtask
  task automatic eof();            drive(2'b11, 16'hFDFD); endtask
  task automatic dat(input logic [15:0] d); drive(2'b00, d); endtask
  task automatic cv();             drive(2'b10, 16'h1234); endtask

  task automatic reset_dut();
    rst = 1'b1; i_enable = 1'b1; i_m_ready = 1'b0;
    idle(); idle();
    rst = 1'b0;
  endtask

  task automatic acquire();
    repeat (6) idle();
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++; if (o_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %0b expected 0", o_sync); end
    n_checks++; if ({o_m_valid, o_m_last, o_m_err, o_m_data} !== 19'h0) begin n_fail++;
      $display("FAIL reset_stream: got v=%0b l=%0b e=%0b d=%h expected all 0", o_m_valid, o_m_last, o_m_err, o_m_data); end
    n_checks++; if ({o_frame_done, o_frame_err, o_loss_irq, o_err_code, o_frame_len} !== 22'h0) begin n_fail++;
      $display("FAIL reset_status: got done=%0b err=%0b loss=%0b code=%0d len=%0d expected all 0",
               o_frame_done, o_frame_err, o_loss_irq, o_err_code, o_frame_len); end
  endtask

  task automatic test_good_frame();
    reset_dut();
    i_m_ready = 1'b1;
    idle(); idle(); idle(); idle(); dat(16'h0055);
    n_checks++; if (o_sync !== 1'b0) begin n_fail++; $display("FAIL sync_early: got %0b expected 0", o_sync); end
    dat(16'h0055);
    n_checks++; if (o_sync !== 1'b1) begin n_fail++; $display("FAIL sync_at_4: got %0b expected 1", o_sync); end
    sof(); dat(16'd3); dat(16'h1111); dat(16'h2222);
    n_checks++; if (o_m_valid !== 1'b0) begin n_fail++; $display("FAIL push_latency_early: valid=%0b expected 0", o_m_valid); end
    dat(16'h3333);
    n_checks++; if (o_m_valid !== 1'b1 || o_m_data !== 16'h1111) begin n_fail++;
      $display("FAIL push_latency: valid=%0b data=%h expected 1/1111", o_m_valid, o_m_data); end
    dat(16'h6666); eof(); idle();
    n_checks++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %0b expected 0", o_frame_done); end
    idle();
    n_checks++; if (o_frame_done !== 1'b1 || o_frame_err !== 1'b0 || o_frame_len !== 16'd3) begin n_fail++;
      $display("FAIL done_pulse: done=%0b err=%0b len=%0d expected 1/0/3", o_frame_done, o_frame_err, o_frame_len); end
    repeat (4) idle();
    n_checks++; if (beats.size() !== 3) begin n_fail++; $display("FAIL good_beat_count: got %0d expected 3", beats.size()); end
    n_checks++; if (beat_at(0) !== 18'h01111 || beat_at(1) !== 18'h02222 || beat_at(2) !== 18'h13333) begin n_fail++;
      $display("FAIL good_beats: got %h %h %h expected 01111 02222 13333", beat_at(0), beat_at(1), beat_at(2)); end
    n_checks++; if (n_done !== 1 || n_err !== 0) begin n_fail++;
      $display("FAIL good_pulses: done=%0d err=%0d expected 1/0", n_done, n_err); end
  endtask

  task automatic test_bad_cksum();
    reset_dut();
    i_m_ready = 1'b1;
    acquire();
    sof(); dat(16'd3); dat(16'h1111); dat(16'h2222); dat(16'h3333); dat(16'h6667); eof();
    repeat (5) idle();
    n_checks++; if (n_err !== 1 || n_done !== 0 || last_code !== 3'd4 || last_len !== 16'd3) begin n_fail++;
      $display("FAIL cksum_status: err=%0d done=%0d code=%0d len=%0d expected 1/0/4/3", n_err, n_done, last_code, last_len); end
    n_checks++; if (beats.size() !== 3 || beat_at(2) !== 18'h13333) begin n_fail++;
      $display("FAIL cksum_beats: count=%0d last=%h expected 3/13333", beats.size(), beat_at(2)); end
  endtask

  task automatic test_overflow();
    reset_dut();
    acquire();
    sof(); dat(16'd100);
    for (int i = 1; i <= 100; i++) dat(16'(i));
    eof(); idle(); idle(); idle();
    n_checks++; if (n_err !== 1 || last_code !== 3'd5 || last_len !== 16'd100) begin n_fail++;
      $display("FAIL ovf_status: err=%0d code=%0d len=%0d expected 1/5/100", n_err, last_code, last_len); end
    n_checks++; if (o_m_valid !== 1'b1 || o_m_data !== 16'd1 || beats.size() !== 0) begin n_fail++;
      $display("FAIL ovf_head: valid=%0b data=%h popped=%0d expected 1/0001/0", o_m_valid, o_m_data, beats.size()); end
    i_m_ready = 1'b1; idle(); i_m_ready = 1'b0; idle();
    i_m_ready = 1'b1;
    repeat (70) idle();
    n_checks++; if (beats.size() !== 65) begin n_fail++; $display("FAIL ovf_beat_count: got %0d expected 65", beats.size()); end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (beat_at(i) !== {2'b00, 16'(i + 1)}) begin n_fail++;
        $display("FAIL ovf_beat_%0d: got %h expected %h", i, beat_at(i), {2'b00, 16'(i + 1)}); end
    end
    n_checks++; if (beat_at(64) !== 18'h30000) begin n_fail++; $display("FAIL ovf_terminator: got %h expected 30000", beat_at(64)); end
    sof(); dat(16'd2); dat(16'h0005); dat(16'h0007); dat(16'h000C); eof();
    repeat (5) idle();
    n_checks++; if (n_done !== 1 || last_len !== 16'd2) begin n_fail++;
      $display("FAIL ovf_next_done: done=%0d len=%0d expected 1/2", n_done, last_len); end
    n_checks++; if (beats.size() !== 67 || beat_at(65) !== 18'h00005 || beat_at(66) !== 18'h10007) begin n_fail++;
      $display("FAIL ovf_next_beats: count=%0d b65=%h b66=%h expected 67/00005/10007", beats.size(), beat_at(65), beat_at(66)); end
  endtask

  task automatic test_loss();
    reset_dut();
    i_m_ready = 1'b1;
    acquire();
    sof(); dat(16'd4); dat(16'h00A1); dat(16'h00A2);
    cv(); cv(); cv(); cv(); cv();
    n_checks++; if (o_sync !== 1'b1) begin n_fail++; $display("FAIL loss_early: sync=%0b expected 1", o_sync); end
    cv();
    n_checks++; if (o_sync !== 1'b0) begin n_fail++; $display("FAIL loss_sync: sync=%0b expected 0", o_sync); end
    idle(); idle(); idle(); idle(); idle();
    n_checks++; if (o_sync !== 1'b0) begin n_fail++; $display("FAIL resync_early: sync=%0b expected 0", o_sync); end
    idle();
    n_checks++; if (o_sync !== 1'b1) begin n_fail++; $display("FAIL resync: sync=%0b expected 1", o_sync); end
    n_checks++; if (n_loss !== 1 || n_err !== 1 || last_code !== 3'd6 || last_len !== 16'd4) begin n_fail++;
      $display("FAIL loss_status: irq=%0d err=%0d code=%0d len=%0d expected 1/1/6/4", n_loss, n_err, last_code, last_len); end
    n_checks++; if (beats.size() !== 3 || beat_at(0) !== 18'h000A1 || beat_at(1) !== 18'h000A2 || beat_at(2) !== 18'h30000) begin n_fail++;
      $display("FAIL loss_beats: count=%0d %h %h %h expected 3 000a1 000a2 30000", beats.size(), beat_at(0), beat_at(1), beat_at(2)); end
  endtask

  task automatic test_len_and_idle();
    reset_dut();
    i_m_ready = 1'b1;
    acquire();
    sof(); dat(16'd0); eof(); repeat (3) idle();
    n_checks++; if (n_err !== 1 || last_code !== 3'd1 || last_len !== 16'd0) begin n_fail++;
      $display("FAIL len_zero: err=%0d code=%0d len=%0d expected 1/1/0", n_err, last_code, last_len); end
    sof(); dat(16'd4097); dat(16'h0001); eof(); repeat (3) idle();
    n_checks++; if (n_err !== 2 || last_code !== 3'd1 || last_len !== 16'd4097) begin n_fail++;
      $display("FAIL len_max: err=%0d code=%0d len=%0d expected 2/1/4097", n_err, last_code, last_len); end
    n_checks++; if (beats.size() !== 0) begin n_fail++; $display("FAIL len_no_push: got %0d beats expected 0", beats.size()); end
    sof(); dat(16'd2); dat(16'h0100); idle(); dat(16'h0200); dat(16'h0300); eof();
    repeat (4) idle();
    n_checks++; if (n_done !== 1 || n_err !== 2 || last_len !== 16'd2) begin n_fail++;
      $display("FAIL idle_skip_status: done=%0d err=%0d len=%0d expected 1/2/2", n_done, n_err, last_len); end
    n_checks++; if (beats.size() !== 2 || beat_at(0) !== 18'h00100 || beat_at(1) !== 18'h10200) begin n_fail++;
      $display("FAIL idle_skip_beats: count=%0d %h %h expected 2 00100 10200", beats.size(), beat_at(0), beat_at(1)); end
  endtask

  task automatic test_abort_and_rst();
    reset_dut();
    i_m_ready = 1'b1;
    acquire();
    sof(); dat(16'd4); dat(16'hAAAA); dat(16'hBBBB); dat(16'hCCCC);
    i_enable = 1'b0;
    dat(16'hDDDD);
    n_checks++; if (o_sync !== 1'b0) begin n_fail++; $display("FAIL abort_sync: sync=%0b expected 0", o_sync); end
    repeat (4) idle();
    n_checks++; if (n_err !== 1 || last_code !== 3'd7 || last_len !== 16'd4 || n_loss !== 0) begin n_fail++;
      $display("FAIL abort_status: err=%0d code=%0d len=%0d irq=%0d expected 1/7/4/0", n_err, last_code, last_len, n_loss); end
    n_checks++; if (beats.size() !== 2 || beat_at(0) !== 18'h0AAAA || beat_at(1) !== 18'h30000) begin n_fail++;
      $display("FAIL abort_beats: count=%0d %h %h expected 2 0aaaa 30000", beats.size(), beat_at(0), beat_at(1)); end
    i_enable = 1'b1; i_m_ready = 1'b0;
    acquire();
    sof(); dat(16'd4); dat(16'h0001); dat(16'h0002); dat(16'h0003); idle(); idle();
    n_checks++; if (o_m_valid !== 1'b1 || o_m_data !== 16'h0001) begin n_fail++;
      $display("FAIL rst_prefill: valid=%0b data=%h expected 1/0001", o_m_valid, o_m_data); end
    rst = 1'b1;
    idle();
    n_checks++; if ({o_m_valid, o_m_data, o_sync, o_frame_done, o_frame_err, o_loss_irq, o_frame_len, o_err_code} !== 40'h0) begin n_fail++;
      $display("FAIL rst_clear: valid=%0b data=%h sync=%0b done=%0b err=%0b irq=%0b len=%0d code=%0d expected all 0",
               o_m_valid, o_m_data, o_sync, o_frame_done, o_frame_err, o_loss_irq, o_frame_len, o_err_code); end
    rst = 1'b0;
    dat(16'h0004); eof(); repeat (4) idle();
    n_checks++; if (n_err !== 0 || n_done !== 0 || o_m_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_quiet: err=%0d done=%0d valid=%0b expected 0/0/0", n_err, n_done, o_m_valid); end
  endtask

  initial begin
    rst = 1'b1; i_enable = 1'b1; i_m_ready = 1'b0;
    i_2711_rkmsb = 1'b0; i_2711_rklsb = 1'b1; i_2711_rxd = 16'hC5BC;
    test_reset();
    test_good_frame();
    test_bad_cksum();
    test_overflow();
    test_loss();
    test_len_and_idle();
    test_abort_and_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
